pmod_debounce: RTL and testbench

Input conditioning stage for the PMOD C header. It sits directly upstream of the PMOD C→A passthrough and feeds its `pmod_c` input. Each raw pin is synchronised into the `clk` domain, debounced per bit with a consecutive-cycle stability counter, and registered as a clean level. The block also emits one-cycle rise/fall event pulses for software-visible or downstream logic.

---
 rtl/pmod_debounce_pkg.sv | 14 +
 rtl/debounce_bit.sv | 70 +++++++
 rtl/pmod_debounce.sv | 50 +++++
 tb/tb_pmod_debounce.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pmod_debounce_pkg.sv
// Shared constants for the PMOD C input conditioning path.
// The passthrough imports the same package so both agree on pin count.
package pmod_debounce_pkg;

    localparam int unsigned PMOD_WIDTH               = 8;
    localparam int unsigned PMOD_DB_CYCLES_DEFAULT   = 100000;
    localparam int unsigned PMOD_SYNC_STAGES_DEFAULT = 2;

    // The counter must hold DB_CYCLES-1, and it must be at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One pin: synchroniser, stability counter, stable level and rise/fall pulse flops.
// accept_o is the next-state acceptance term so the parent can register a matching flag.
module debounce_bit
    import pmod_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = PMOD_SYNC_STAGES_DEFAULT,
    parameter int unsigned DB_CYCLES   = PMOD_DB_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic accept_o
);

    localparam int unsigned CntW = cnt_width(DB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   q_q, q_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        q_d    = q_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        accept = 1'b0;
        if (s != q_q) begin
            if (cnt_q == CntMax) begin
                accept = 1'b1;
                q_d    = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            q_q    <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o  = q_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign accept_o = accept;

endmodule

// File: rtl/pmod_debounce.sv
// PMOD C input conditioning: per-pin sync + debounce, clean levels and edge pulses.
// Feeds the pmod_c input of the C->A passthrough.
module pmod_debounce
    import pmod_debounce_pkg::*;
#(
    parameter int unsigned WIDTH       = PMOD_WIDTH,
    parameter int unsigned SYNC_STAGES = PMOD_SYNC_STAGES_DEFAULT,
    parameter int unsigned DB_CYCLES   = PMOD_DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pmod_c_raw,
    output logic [WIDTH-1:0] pmod_c,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    logic [WIDTH-1:0] accept;
    logic             any_change_q, any_change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_bit (
            .clk_i    (clk),
            .rst_i    (rst),
            .raw_i    (pmod_c_raw[i]),
            .level_o  (pmod_c[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .accept_o (accept[i])
        );
    end

    // Built from the same next-state terms as the pulses so it lands in their cycle.
    assign any_change_d = |accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_pmod_debounce.sv
// Scoreboard bench for pmod_debounce with WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4.
// Stimulus queues expected acceptance events; the monitor checks each output event.
module tb_pmod_debounce;

    localparam int unsigned W   = 8;
    localparam int          LAT = 6;  // edges from driving raw to seeing pmod_c change

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = 8'hFF;
    logic [W-1:0] pmod_c, rise, fall;
    logic         any_change;

    int           edge_cnt = 0;
    int           n_cmp = 0;
    int           n_fail = 0;
    bit           mon_en = 1'b0;
    bit           expect_zero = 1'b0;
    logic [W-1:0] last_pmod = '0;

    typedef struct {
        int           cyc;
        logic [W-1:0] pmod;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur;

    pmod_debounce #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pmod_c_raw (raw),
        .pmod_c     (pmod_c),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input int cyc, input logic [W-1:0] p, input logic [W-1:0] r,
                                input logic [W-1:0] f);
        ev_t e;
        e.cyc  = cyc;
        e.pmod = p;
        e.rise = r;
        e.fall = f;
        exp_q.push_back(e);
    endtask

    task automatic step_to(input logic [W-1:0] v, input logic [W-1:0] r, input logic [W-1:0] f);
        raw = v;
        expect_event(edge_cnt + LAT, v, r, f);
        cycles(12);
    endtask

    // Hold reset for three edges; after release the held input must be re-accepted.
    task automatic do_reset(input logic [W-1:0] r_exp);
        rst = 1'b1;
        cycles(1);
        expect_zero = 1'b1;
        mon_en      = 1'b1;
        cycles(2);
        rst = 1'b0;
        expect_event(edge_cnt + LAT, raw, r_exp, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1 expect_zero = 1'b0;
        cycles(10);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed_event: expected at edge %0d, nothing observed by edge %0d",
                         exp_q[0].cyc, edge_cnt);
                void'(exp_q.pop_front());
            end
            if (expect_zero) begin
                n_cmp++;
                if ({pmod_c, rise, fall, any_change} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_zero @%0d: pmod_c=%h rise=%h fall=%h any=%b, need all 0",
                             edge_cnt, pmod_c, rise, fall, any_change);
                end
            end else if (pmod_c !== last_pmod || rise !== '0 || fall !== '0 ||
                         any_change !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event @%0d: pmod_c=%h rise=%h fall=%h any=%b",
                             edge_cnt, pmod_c, rise, fall, any_change);
                end else begin
                    cur = exp_q.pop_front();
                    n_cmp++;
                    if (edge_cnt != cur.cyc) begin
                        n_fail++;
                        $display("FAIL event_cycle: got edge %0d, need edge %0d", edge_cnt, cur.cyc);
                    end
                    n_cmp++;
                    if ({pmod_c, rise, fall, any_change} !== {cur.pmod, cur.rise, cur.fall, 1'b1})
                    begin
                        n_fail++;
                        $display("FAIL event_value @%0d: got pmod_c=%h rise=%h fall=%h any=%b, need %h %h %h 1",
                                 edge_cnt, pmod_c, rise, fall, any_change,
                                 cur.pmod, cur.rise, cur.fall);
                    end
                end
            end
            last_pmod = pmod_c;
        end
    end

    initial begin
        // Reset with all pins high, then a full rise on every bit.
        raw = 8'hFF;
        do_reset(8'hFF);

        // Clean step on bit 0 (clear to 0 first).
        step_to(8'h00, 8'h00, 8'hFF);
        step_to(8'h01, 8'h01, 8'h00);

        // Three-cycle glitch on bit 3: one short of acceptance.
        raw = 8'h09;
        cycles(3);
        raw = 8'h01;
        cycles(20);

        // Simultaneous multi-bit changes.
        step_to(8'h00, 8'h00, 8'h01);
        step_to(8'hA5, 8'hA5, 8'h00);
        step_to(8'h5A, 8'h5A, 8'hA5);

        // Bounce on bit 7: 1,0,1,1,0 then high; last 0 is entry 4 -> accept 11 edges on.
        begin
            logic [8:0] pat;
            pat = 9'b1_1110_1101;  // entry i is pat[i]
            expect_event(edge_cnt + 11, 8'hDA, 8'h80, 8'h00);
            for (int i = 0; i < 9; i++) begin
                raw = pat[i] ? 8'hDA : 8'h5A;
                cycles(1);
            end
            raw = 8'hDA;
            cycles(10);
        end

        // Reset while the rising bits have cnt == 2.
        raw = 8'hFF;
        cycles(4);
        do_reset(8'hFF);

        cycles(10);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: %0d still queued, need 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
